contador_anel_param: RTL and testbench

- Parametrised synchronous shift-register counter. Runtime-selectable ring (one-hot) or Johnson (twisted ring) mode, plus up/down direction.
- Adds parallel load, illegal-state detection with self-correction, a position index output and a wrap pulse.
- Used as a sequencer and phase generator in the course datapath labs.
- Replaces the ripple JK-based counters with a single clock domain.

---
 rtl/contador_pkg.sv | 25 ++
 rtl/anel_decod.sv | 52 +++++
 rtl/contador_anel_param.sv | 77 +++++++
 tb/tb_contador_anel_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the ring/Johnson shift-register counter.
package contador_pkg;

    localparam logic MODO_ANEL    = 1'b0;
    localparam logic MODO_JOHNSON = 1'b1;

    // Widest counter supported; seed() returns a vector of this width.
    localparam int unsigned MAX_WIDTH = 16;

    // Number of distinct states in the sequence of the given mode.
    function automatic int unsigned seq_len(input logic modo, input int unsigned w);
        return (modo == MODO_JOHNSON) ? 2 * w : w;
    endfunction

    // Starting state: 0..01 for ring, all zeros for Johnson.
    function automatic logic [MAX_WIDTH-1:0] seed(input logic modo, input int unsigned w);
        logic [MAX_WIDTH-1:0] s;
        s = '0;
        if (modo == MODO_ANEL && w > 0) begin
            s[0] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/anel_decod.sv
// Combinational legality check and position encoder for ring/Johnson states.
module anel_decod
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             modo_i,
    output logic [IW-1:0]    idx_o,
    output logic             illegal_o
);

    int unsigned    ones_c;
    int unsigned    edges_c;
    logic [IW-1:0]  ring_idx_c;

    // Count set bits, adjacent-bit transitions and remember the set bit position.
    always_comb begin
        ones_c     = 0;
        edges_c    = 0;
        ring_idx_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (q_i[i]) begin
                ones_c     = ones_c + 1;
                ring_idx_c = IW'(i);
            end
        end
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (q_i[i] != q_i[i+1]) begin
                edges_c = edges_c + 1;
            end
        end
    end

    // Legality and index per mode; illegal states report index 0.
    always_comb begin
        illegal_o = 1'b0;
        idx_o     = '0;
        if (modo_i == MODO_ANEL) begin
            illegal_o = (ones_c != 1);
            idx_o     = illegal_o ? '0 : ring_idx_c;
        end else begin
            illegal_o = (edges_c > 1);
            if (!illegal_o) begin
                // Filling phase counts ones up; draining phase counts back from 2W.
                idx_o = q_i[WIDTH-1] ? IW'(2 * WIDTH - ones_c) : IW'(ones_c);
            end
        end
    end

endmodule

// File: rtl/contador_anel_param.sv
// Parametrised ring / Johnson counter with load, self-correction, index and wrap pulse.
module contador_anel_param
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned IW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             dir,
    input  logic             modo,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             wrap_d, wrap_q;
    logic [WIDTH-1:0] seed_c;
    logic [WIDTH-1:0] step_c;
    logic [IW-1:0]    last_idx_c;

    anel_decod #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decod (
        .q_i       (q_q),
        .modo_i    (modo),
        .idx_o     (idx),
        .illegal_o (illegal)
    );

    assign seed_c     = WIDTH'(seed(modo, WIDTH));
    assign last_idx_c = IW'(seq_len(modo, WIDTH) - 1);

    // Shifted state for a legal step; Johnson feeds back the inverted outgoing bit.
    always_comb begin
        step_c = q_q;
        unique case ({modo, dir})
            {MODO_ANEL, 1'b0}:    step_c = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            {MODO_ANEL, 1'b1}:    step_c = {q_q[0], q_q[WIDTH-1:1]};
            {MODO_JOHNSON, 1'b0}: step_c = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            {MODO_JOHNSON, 1'b1}: step_c = {~q_q[0], q_q[WIDTH-1:1]};
            default:              step_c = q_q;
        endcase
    end

    // Next state: clear > load > correction > step > hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clear) begin
            q_d = seed_c;
        end else if (load) begin
            q_d = d;
        end else if (en && illegal) begin
            q_d = seed_c;
        end else if (en) begin
            q_d    = step_c;
            wrap_d = dir ? (idx == '0) : (idx == last_idx_c);
        end
    end

    // State registers with synchronous active-high clear folded into q_d.
    always_ff @(posedge clk) begin
        q_q    <= q_d;
        wrap_q <= wrap_d;
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_anel_param.sv
// Self-checking bench: directed plan plus random stimulus against a sequence-table model.
module tb_contador_anel_param;

    localparam int unsigned W  = 5;
    localparam int unsigned IW = $clog2(2 * W);

    logic          clk = 1'b0;
    logic          clear, en, dir, modo, load;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic [IW-1:0] idx;
    logic          wrap, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq;
    logic         mwrap;

    always #5 clk = ~clk;

    contador_anel_param #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .dir     (dir),
        .modo    (modo),
        .load    (load),
        .d       (d),
        .q       (q),
        .idx     (idx),
        .wrap    (wrap),
        .illegal (illegal)
    );

    // State number p of the legal sequence for mode m.
    function automatic logic [W-1:0] seq_state(input bit m, input int p);
        int full;
        full = (1 << W) - 1;
        if (!m) return W'(1 << p);
        if (p <= int'(W)) return W'((1 << p) - 1);
        return W'(full & ~((1 << (p - int'(W))) - 1));
    endfunction

    function automatic int seq_n(input bit m);
        return m ? 2 * int'(W) : int'(W);
    endfunction

    // Position of v in the legal sequence, -1 when not a member.
    function automatic int pos_of(input bit m, input logic [W-1:0] v);
        for (int p = 0; p < seq_n(m); p++) begin
            if (seq_state(m, p) === v) return p;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cyc(input bit c, input bit l, input bit e, input bit dr, input bit m,
                       input logic [W-1:0] dv);
        int p, np, n;
        @(negedge clk);
        clear = c; load = l; en = e; dir = dr; modo = m; d = dv;
        @(posedge clk);
        #1;
        n = seq_n(m);
        if (c) begin
            mq = seq_state(m, 0); mwrap = 1'b0;
        end else if (l) begin
            mq = dv; mwrap = 1'b0;
        end else if (e) begin
            p = pos_of(m, mq);
            if (p < 0) begin
                mq = seq_state(m, 0); mwrap = 1'b0;
            end else begin
                np    = dr ? (p + n - 1) % n : (p + 1) % n;
                mwrap = dr ? (p == 0) : (p == n - 1);
                mq    = seq_state(m, np);
            end
        end else begin
            mwrap = 1'b0;
        end
        p = pos_of(m, mq);
        check("q", 32'(q), 32'(mq));
        check("wrap", 32'(wrap), 32'(mwrap));
        check("illegal", 32'(illegal), 32'(p < 0));
        check("idx", 32'(idx), 32'((p < 0) ? 0 : p));
    endtask

    logic [W-1:0] jexp [10];

    initial begin
        clear = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; modo = 1'b0; d = '0;
        mq = '0; mwrap = 1'b0;
        jexp = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h10, 5'h00};

        // Johnson full cycle upward
        cyc(1, 0, 0, 0, 1, '0);
        check("reset_q", 32'(q), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 1, '0);
            check("j_seq_q", 32'(q), 32'(jexp[i]));
            check("j_seq_idx", 32'(idx), 32'((i + 1) % 10));
            check("j_seq_wrap", 32'(wrap), 32'(i == 9));
        end

        // Ring downward from seed wraps to MSB
        cyc(1, 0, 0, 0, 0, '0);
        check("ring_seed", 32'(q), 32'h01);
        cyc(0, 0, 1, 1, 0, '0);
        check("ring_dn_q", 32'(q), 32'h10);
        check("ring_dn_idx", 32'(idx), 32'd4);
        check("ring_dn_wrap", 32'(wrap), 32'd1);
        cyc(0, 0, 1, 1, 0, '0);
        check("ring_dn2_q", 32'(q), 32'h08);
        check("ring_dn2_wrap", 32'(wrap), 32'd0);

        // Illegal load holds while disabled, then self-corrects
        cyc(0, 1, 1, 0, 1, 5'b10101);
        check("load_ill_q", 32'(q), 32'h15);
        check("load_ill_flag", 32'(illegal), 32'd1);
        check("load_ill_idx", 32'(idx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, '0);
            check("hold_ill_q", 32'(q), 32'h15);
        end
        cyc(0, 0, 1, 0, 1, '0);
        check("corr_q", 32'(q), 32'h00);
        check("corr_wrap", 32'(wrap), 32'd0);

        // Clear beats load
        cyc(1, 1, 0, 0, 1, 5'h1F);
        check("clr_over_load", 32'(q), 32'h00);

        // Mode switch makes the state illegal
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1, '0);
        check("pre_sw_idx", 32'(idx), 32'd4);
        cyc(0, 0, 0, 0, 0, '0);
        check("sw_illegal", 32'(illegal), 32'd1);
        cyc(0, 0, 1, 0, 0, '0);
        check("sw_corr_q", 32'(q), 32'h01);
        check("sw_corr_idx", 32'(idx), 32'd0);

        // Johnson wrap in both directions
        cyc(1, 0, 0, 0, 1, '0);
        cyc(0, 0, 1, 1, 1, '0);
        check("j_dn_q", 32'(q), 32'h10);
        check("j_dn_idx", 32'(idx), 32'd9);
        check("j_dn_wrap", 32'(wrap), 32'd1);
        cyc(0, 0, 1, 0, 1, '0);
        check("j_up_q", 32'(q), 32'h00);
        check("j_up_wrap", 32'(wrap), 32'd1);

        // Random mix of controls, mode switches and loads
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom),
                ($urandom_range(0, 24) == 0) ? ~modo : modo, W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
